instr_fetch: RTL and testbench

Instruction fetch unit for the single-cycle-decode LEGv8 datapath: owns the program counter, issues word reads to instruction memory, and presents the fetched 32-bit `instruction` to `instr_decoder`. Consumes the decoder's branch controls (`UncondBr`, `BrTaken`) and branch fields (`CondAddr19`, `BrAddr26`) to select the next PC. It is the producer end of the decoder's instruction/branch interface.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/br_target.sv | 25 ++
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the LEGv8 instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic [63:0] sext19(input logic [18:0] v);
        return {{45{v[18]}}, v};
    endfunction

    function automatic logic [63:0] sext26(input logic [25:0] v);
        return {{38{v[25]}}, v};
    endfunction

endpackage

// File: rtl/br_target.sv
// Next-PC computation: sequential +4 or PC-relative branch with word offset.
module br_target
    import fetch_pkg::*;
(
    input  logic [63:0] i_pc,
    input  logic        i_br_taken,
    input  logic        i_uncond_br,
    input  logic [18:0] i_cond_addr19,
    input  logic [25:0] i_br_addr26,
    output logic [63:0] o_next_pc
);

    logic [63:0] w_offset;
    logic [63:0] w_seq_pc;
    logic [63:0] w_br_pc;

    always_comb begin
        w_offset  = i_uncond_br ? sext26(i_br_addr26) : sext19(i_cond_addr19);
        w_seq_pc  = i_pc + 64'(INSTR_BYTES);
        // Offsets count words; shifting the sign-extended value keeps negative targets correct.
        w_br_pc   = i_pc + (w_offset << 2);
        o_next_pc = i_br_taken ? w_br_pc : w_seq_pc;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, single-outstanding memory handshake, and
// the registered instruction presented to the decoder.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        UncondBr,
    input  logic        BrTaken,
    input  logic [18:0] CondAddr19,
    input  logic [25:0] BrAddr26,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [63:0] pc,
    output logic [31:0] retired
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_retired;
    logic [63:0] w_next_pc;
    logic        w_accept;
    logic        w_advance;

    br_target u_br_target (
        .i_pc          (r_pc),
        .i_br_taken    (BrTaken),
        .i_uncond_br   (UncondBr),
        .i_cond_addr19 (CondAddr19),
        .i_br_addr26   (BrAddr26),
        .o_next_pc     (w_next_pc)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            S_IDLE: w_state_next = S_REQ;
            S_REQ:  w_state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    w_advance    = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_advance) begin
                r_pc          <= w_next_pc;
                r_retired     <= r_retired + 32'd1;
                r_instr_valid <= 1'b0;
            end
        end
    end

    // Request is a pure decode of registered state, so it cannot glitch.
    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised self-checking bench for instr_fetch against a transaction-level PC model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        UncondBr;
    logic        BrTaken;
    logic [18:0] CondAddr19;
    logic [25:0] BrAddr26;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [31:0] retired;

    localparam logic [63:0] RST_PC = 64'h100;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .UncondBr    (UncondBr),
        .BrTaken     (BrTaken),
        .CondAddr19  (CondAddr19),
        .BrAddr26    (BrAddr26),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: what the unit should be fetching and how many have retired.
    logic [63:0] m_pc;
    logic [31:0] m_retired;
    logic [31:0] m_instr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req, 0);
        check({tag, "_addr"},  imem_addr, RST_PC);
        check({tag, "_pc"},    pc, RST_PC);
        check({tag, "_instr"}, instruction, 0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_ret"},   retired, 0);
    endtask

    function automatic logic [63:0] model_next(input logic [63:0] cur, input logic bt, input logic ub,
                                               input logic [18:0] c19, input logic [25:0] b26);
        longint off;
        if (!bt) return cur + 64'd4;
        off = ub ? longint'($signed(b26)) : longint'($signed(c19));
        return cur + 64'(off * 4);
    endfunction

    // Entered with the DUT just having moved into REQ (sampled #1 after the edge).
    task automatic fetch(input int lat, input int stl, input logic [31:0] data,
                         input logic bt, input logic ub, input logic [18:0] c19,
                         input logic [25:0] b26, input logic spur);
        check("req_pulse", imem_req, 1);
        check("req_addr", imem_addr, m_pc);
        @(posedge clk); #1;
        for (int k = 1; k < lat; k++) begin
            check("wait_noreq", imem_req, 0);
            check("wait_nvalid", instr_valid, 0);
            @(posedge clk); #1;
        end
        check("wait_noreq", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        m_instr     = data;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("exec_instr", instruction, m_instr);
        check("exec_valid", instr_valid, 1);
        check("exec_pc", pc, m_pc);
        check("exec_noreq", imem_req, 0);
        for (int k = 0; k < stl; k++) begin
            stall       = 1'b1;
            imem_rvalid = spur | ($urandom_range(0, 1) == 1);
            imem_rdata  = $urandom;
            BrTaken     = 1'($urandom_range(0, 1));
            UncondBr    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("stall_instr", instruction, m_instr);
            check("stall_pc", pc, m_pc);
            check("stall_ret", retired, m_retired);
            check("stall_valid", instr_valid, 1);
            check("stall_noreq", imem_req, 0);
        end
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        BrTaken     = bt;
        UncondBr    = ub;
        CondAddr19  = c19;
        BrAddr26    = b26;
        @(posedge clk); #1;
        m_pc      = model_next(m_pc, bt, ub, c19, b26);
        m_retired = m_retired + 32'd1;
        check("retire_valid", instr_valid, 0);
        check("retire_cnt", retired, m_retired);
        check("retire_pc", pc, m_pc);
        BrTaken    = 1'($urandom_range(0, 1));
        UncondBr   = 1'($urandom_range(0, 1));
        CondAddr19 = 19'($urandom);
        BrAddr26   = 26'($urandom);
    endtask

    initial begin
        logic [18:0] c19;
        logic [63:0] tgt;
        reset       = 1'b1;
        stall       = 1'b0;
        UncondBr    = 1'b0;
        BrTaken     = 1'b0;
        CondAddr19  = '0;
        BrAddr26    = '0;
        imem_rdata  = '0;
        imem_rvalid = 1'b0;
        m_pc        = RST_PC;
        m_retired   = '0;
        m_instr     = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check("idle_noreq", imem_req, 0);
        @(posedge clk); #1;

        // Directed: sequential fetches, unconditional back-branch, conditional forward branch.
        fetch(1, 0, 32'h8B1F03E0, 1'b0, 1'b0, 19'h0, 26'h0, 1'b0);
        fetch(1, 0, 32'h11111111, 1'b0, 1'b1, 19'h7FFFF, 26'h0, 1'b0);
        fetch(1, 0, 32'h22222222, 1'b1, 1'b1, 19'h0, 26'h3FFFFFE, 1'b0);
        check("branch_back_pc", m_pc, 64'h100);
        fetch(1, 0, 32'h33333333, 1'b1, 1'b0, 19'h00005, 26'h0, 1'b0);
        fetch(1, 5, 32'h44444444, 1'b0, 1'b0, 19'h0, 26'h0, 1'b1);
        fetch(7, 0, 32'h55555555, 1'b0, 1'b0, 19'h0, 26'h0, 1'b0);

        // Branch to the top of the address space and let +4 wrap to zero.
        tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        c19 = 19'((tgt - m_pc) >> 2);
        fetch(2, 1, 32'h66666666, 1'b1, 1'b0, c19, 26'h0, 1'b0);
        fetch(1, 0, 32'h77777777, 1'b0, 1'b0, 19'h0, 26'h0, 1'b0);
        fetch(1, 0, 32'h88888888, 1'b0, 1'b0, 19'h0, 26'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            fetch($urandom_range(1, 4), $urandom_range(0, 3), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  19'($urandom), 26'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of WAIT must clear everything asynchronously.
        check("pre_abort_req", imem_req, 1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        m_pc      = RST_PC;
        m_retired = '0;
        @(posedge clk); #1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        reset = 1'b0;
        #1;
        check("post_idle_noreq", imem_req, 0);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        check("post_abort_instr", instruction, 0);
        fetch(3, 0, 32'h9ABCDEF0, 1'b0, 1'b0, 19'h0, 26'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
